// File: rtl/dmem_ctrl.sv
// dmem_ctrl: 256x16 data memory on the CPU data port with a handshaked host
// port. CPU accesses always win; host accesses are sequenced by a small FSM.
// Optional build macro DMEM_INIT_CLEAR_EN adds a post-reset sweep that zeroes
// the whole array before init_done is raised.
module dmem_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_dataout,
  input  logic              d_we,
  output logic [DATA_W-1:0] d_datain,
  input  logic              h_req,
  input  logic              h_we,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DATA_W-1:0] h_wdata,
  output logic              h_ack,
  output logic [DATA_W-1:0] h_rdata,
  output logic              init_done,
  output logic [15:0]       cpu_wr_cnt
);

`ifdef DMEM_INIT_CLEAR_EN
  typedef enum logic [1:0] {INIT, IDLE, ACCESS, RESP} state_t;
  localparam state_t RESET_STATE = INIT;
  logic [ADDR_W-1:0] sweep_cnt;
`else
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  localparam state_t RESET_STATE = IDLE;
`endif

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              cpu_wr;
  logic              host_blocked;
  logic              host_wr;

  // CPU write qualification and host-write collision detection
  always_comb begin
    cpu_wr = enable && d_we;
`ifdef DMEM_INIT_CLEAR_EN
    if (state == INIT) cpu_wr = 1'b0;
`endif
    host_blocked = cpu_wr && (d_addr == addr_q);
    host_wr      = (state == ACCESS) && we_q && !host_blocked;
  end

  assign d_datain = mem[d_addr];

  // Memory write ports: CPU, host (never the same address), and init sweep
  always_ff @(posedge clock) begin
    if (reset) begin
      if (cpu_wr)  mem[d_addr] <= d_dataout;
      if (host_wr) mem[addr_q] <= wdata_q;
`ifdef DMEM_INIT_CLEAR_EN
      if (state == INIT) mem[sweep_cnt] <= '0;
`endif
    end
  end

  // Host sequencing FSM with registered ack/read data
  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= RESET_STATE;
      h_ack     <= 1'b0;
      h_rdata   <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      init_done <= 1'b0;
`ifdef DMEM_INIT_CLEAR_EN
      sweep_cnt <= '0;
`endif
    end else begin
      h_ack <= 1'b0;
`ifndef DMEM_INIT_CLEAR_EN
      init_done <= 1'b1;
`endif
      case (state)
`ifdef DMEM_INIT_CLEAR_EN
        INIT: begin
          sweep_cnt <= sweep_cnt + ADDR_W'(1);
          if (sweep_cnt == ADDR_W'(DEPTH - 1)) begin
            state     <= IDLE;
            init_done <= 1'b1;
          end
        end
`endif
        IDLE: begin
          if (h_req && !cpu_wr) begin
            we_q    <= h_we;
            addr_q  <= h_addr;
            wdata_q <= h_wdata;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          // a colliding CPU store is retried past so the host write lands last
          if (!we_q) begin
            h_rdata <= mem[addr_q];
            h_ack   <= 1'b1;
            state   <= RESP;
          end else if (!host_blocked) begin
            h_ack <= 1'b1;
            state <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Saturating count of accepted CPU writes
  always_ff @(posedge clock) begin
    if (!reset) begin
      cpu_wr_cnt <= '0;
    end else if (cpu_wr && (cpu_wr_cnt != '1)) begin
      cpu_wr_cnt <= cpu_wr_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: randomized scoreboard bench for dmem_ctrl. A driver issues CPU
// and host traffic and keeps an array model of memory; host responses are
// queued with their expected ack edge and checked by an independent monitor.
module tb_dmem_ctrl;
  localparam int AW    = 8;
  localparam int DW    = 16;
  localparam int DEPTH = 256;
`ifdef DMEM_INIT_CLEAR_EN
  localparam int unsigned INIT_CYC = DEPTH;
`else
  localparam int unsigned INIT_CYC = 1;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_dataout = '0;
  logic          d_we = 1'b0;
  logic [DW-1:0] d_datain;
  logic          h_req = 1'b0;
  logic          h_we = 1'b0;
  logic [AW-1:0] h_addr = '0;
  logic [DW-1:0] h_wdata = '0;
  logic          h_ack;
  logic [DW-1:0] h_rdata;
  logic          init_done;
  logic [15:0]   cpu_wr_cnt;

  dmem_ctrl #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .d_addr(d_addr), .d_dataout(d_dataout), .d_we(d_we), .d_datain(d_datain),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_ack(h_ack), .h_rdata(h_rdata), .init_done(init_done),
    .cpu_wr_cnt(cpu_wr_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    int unsigned ack_edge;
    bit          chk;
    logic [15:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] m_mem [DEPTH];
  bit          m_known [DEPTH];
  logic [15:0] m_cnt = '0;
  bit          m_init = 1'b0;
  int unsigned m_since = 0;
  int unsigned edge_cnt = 0;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  bit          mon_on = 1'b0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_cnt);
    end
  endfunction

  always @(posedge clock) edge_cnt++;

  // One clock of stimulus; the model absorbs the edge's effects afterwards.
  task automatic step();
    bit          eff;
    bit          rst_edge;
    logic [7:0]  a;
    logic [15:0] d;
    bit          wr_ok;
`ifdef DMEM_INIT_CLEAR_EN
    wr_ok = m_init;
`else
    wr_ok = 1'b1;
`endif
    eff      = enable && d_we && reset && wr_ok;
    rst_edge = !reset;
    a = d_addr;
    d = d_dataout;
    @(posedge clock);
    if (rst_edge) begin
      m_since = 0;
      m_init  = 1'b0;
      m_cnt   = '0;
`ifdef DMEM_INIT_CLEAR_EN
      for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
`endif
    end else begin
      if (eff) begin
        m_mem[a]   = d;
        m_known[a] = 1'b1;
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end
      if (!m_init) begin
        m_since++;
        if (m_since >= INIT_CYC) begin
          m_init = 1'b1;
`ifdef DMEM_INIT_CLEAR_EN
          for (int i = 0; i < DEPTH; i++) begin
            m_mem[i]   = '0;
            m_known[i] = 1'b1;
          end
`endif
        end
      end
    end
    #1;
  endtask

  task automatic cpu_rand();
    enable    = 1'($urandom);
    d_we      = 1'($urandom);
    d_addr    = 8'($urandom_range(0, 19));
    d_dataout = 16'($urandom);
    step();
  endtask

  // Host transaction: stalls = CPU-write cycles holding off acceptance;
  // coll = same-address CPU writes during ACCESS (each delays a host write).
  task automatic host_txn(input bit we, input logic [7:0] a, input logic [15:0] wd,
                          input int unsigned stalls, input int unsigned coll);
    exp_t e;
    h_req = 1'b1; h_we = we; h_addr = a; h_wdata = wd;
    for (int unsigned i = 0; i < stalls; i++) begin
      enable = 1'b1; d_we = 1'b1;
      d_addr = 8'($urandom); d_dataout = 16'($urandom);
      step();
    end
    enable = 1'($urandom); d_we = 1'b0; d_addr = 8'($urandom);
    step();
    e.ack_edge = edge_cnt + 1 + (we ? coll : 0);
    e.chk      = !we && m_known[a];
    e.rdata    = m_mem[a];
    exp_q.push_back(e);
    if (we) begin
      for (int unsigned i = 0; i < coll; i++) begin
        enable = 1'b1; d_we = 1'b1; d_addr = a; d_dataout = 16'($urandom);
        step();
      end
      enable = 1'b1; d_we = 1'($urandom);
      d_addr = a + 8'($urandom_range(1, 255)); d_dataout = 16'($urandom);
      step();
      m_mem[a]   = wd;
      m_known[a] = 1'b1;
    end else begin
      enable = 1'b1; d_we = (coll != 0); d_addr = a; d_dataout = 16'($urandom);
      step();
    end
    h_req = 1'b0;
    cpu_rand();
  endtask

  // Monitor: memory/count/init each cycle, host acks against the queue
  always @(negedge clock) begin : mon
    bit exp_ack;
    if (mon_on) begin
      exp_ack = 1'b0;
      if (m_known[d_addr]) check("d_datain", 32'(d_datain), 32'(m_mem[d_addr]));
      check("cpu_wr_cnt", 32'(cpu_wr_cnt), 32'(m_cnt));
      check("init_done", 32'(init_done), 32'(m_init));
      if (exp_q.size() > 0 && exp_q[0].ack_edge == edge_cnt) exp_ack = 1'b1;
      check("h_ack", 32'(h_ack), 32'(exp_ack));
      if (exp_ack) begin
        if (h_ack && exp_q[0].chk) check("h_rdata", 32'(h_rdata), 32'(exp_q[0].rdata));
        void'(exp_q.pop_front());
      end else if (exp_q.size() > 0 && exp_q[0].ack_edge < edge_cnt) begin
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin : watchdog
    #10000000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int unsigned budget;
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]   = '0;
      m_known[i] = 1'b0;
    end
    reset = 1'b0;
    step();
    step();
    mon_on = 1'b1;
    check("h_rdata_rst", 32'(h_rdata), 32'h0);
    check("h_ack_rst", 32'(h_ack), 32'h0);
    reset = 1'b1;
`ifdef DMEM_INIT_CLEAR_EN
    repeat (5) step();
    enable = 1'b1; d_we = 1'b1; d_addr = 8'h10; d_dataout = 16'hBEEF;
    step();
    d_we = 1'b0;
    budget = 0;
    while (!m_init && budget < 400) begin step(); budget++; end
    enable = 1'b1; d_we = 1'b1; d_addr = 8'h10; d_dataout = 16'hBEEF;
    step();
    d_we = 1'b0;
    reset = 1'b0;
    step(); step();
    reset = 1'b1;
    budget = 0;
    while (!m_init && budget < 400) begin step(); budget++; end
    d_addr = 8'h10;
    #3 check("sweep_clear_10", 32'(d_datain), 32'h0000);
`else
    step();
`endif
    for (int i = 0; i < 20; i++) host_txn(1'b1, 8'(i), 16'($urandom), 0, 0);

    host_txn(1'b1, 8'h05, 16'h2222, 0, 0);
    d_we = 1'b0; d_addr = 8'h05;
    #3 check("host_wr_05", 32'(d_datain), 32'h2222);

    enable = 1'b1; d_we = 1'b1; d_addr = 8'h07; d_dataout = 16'h1111;
    step();
    d_we = 1'b0;
    host_txn(1'b0, 8'h07, 16'h0, 0, 0);
    enable = 1'b0; d_we = 1'b1; d_addr = 8'h07; d_dataout = 16'h9999;
    step();
    d_we = 1'b0;
    host_txn(1'b0, 8'h07, 16'h0, 0, 0);

    host_txn(1'b1, 8'h20, 16'hAAAA, 0, 1);
    d_we = 1'b0; d_addr = 8'h20;
    #3 check("collide_20", 32'(d_datain), 32'hAAAA);
    host_txn(1'b1, 8'h21, 16'h5A5A, 0, 2);
    host_txn(1'b1, 8'h31, 16'h3131, 5, 0);
    host_txn(1'b0, 8'h07, 16'h0, 0, 1);

    repeat (300) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 4)) cpu_rand();
      end else begin
        host_txn(1'($urandom), 8'($urandom_range(0, 19)), 16'($urandom),
                 $urandom_range(0, 3), $urandom_range(0, 2));
      end
    end

    enable = 1'b1; d_we = 1'b1;
    budget = 0;
    while (m_cnt != 16'hFFFE && budget < 70000) begin
      d_addr = 8'($urandom); d_dataout = 16'($urandom);
      step();
      budget++;
    end
    repeat (3) begin
      d_addr = 8'($urandom); d_dataout = 16'($urandom);
      step();
    end
    d_we = 1'b0;
    #3 check("cnt_saturated", 32'(cpu_wr_cnt), 32'hFFFF);

    h_req = 1'b1; h_we = 1'b1; h_addr = 8'h30; h_wdata = 16'h1234;
    step();
    reset = 1'b0; h_req = 1'b0;
    step(); step();
    m_known[8'h30] = 1'b0;
    reset = 1'b1;
    repeat (100) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    repeat (INIT_CYC + 4) step();
    check("init_after_restart", 32'(init_done), 32'h1);

    host_txn(1'b1, 8'h40, 16'h4444, 0, 0);
    host_txn(1'b0, 8'h40, 16'h0, 1, 1);
    repeat (4) step();
    check("pending_acks", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
